// File: rtl/uart_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler_if
// Bundles the two requester handshakes and the transmitter data path that
// the scheduler arbitrates.
//
// Handshake rule (both requesters): a requester raises reqN_valid with
// stable reqN_data and holds both until it sees reqN_ready. The transfer
// happens on the rising clock edge where reqN_valid & reqN_ready are both
// high. reqN_ready is a combinational accept strobe and is never high when
// the scheduler is not idle. A requester may drop valid without a transfer.
//
// Transmitter side: tx_data_valid is a one-cycle start pulse with tx_p_data
// stable; tx_busy is the transmitter's Busy output fed back.
//
// Modports:
//   slave  - the scheduler (accepts requests, drives the transmitter)
//   master - the requesters and transmitter around it
// ---------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
  parameter int DW = 8
);
  logic            req0_valid;
  logic [DW-1:0]   req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [2*DW-1:0] req1_data;
  logic            req1_ready;
  logic [DW-1:0]   tx_p_data;
  logic            tx_data_valid;
  logic            tx_busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    output req0_ready, req1_ready, tx_p_data, tx_data_valid
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    input  req0_ready, req1_ready, tx_p_data, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter between a byte requester (req0) and a word
// requester (req1, 2*DATA_WIDTH). Round-robin grant, words go out as two
// frames low byte first, and a start pulse that the transmitter does not
// acknowledge with tx_busy within ACK_TO cycles is re-issued.
//
// Ports:
//   CLK         rising-edge clock
//   RST         asynchronous active-low reset
//   bus         uart_tx_scheduler_if.slave: requester handshakes and the
//               transmitter's tx_p_data / tx_data_valid / tx_busy
//   sched_busy  registered, high whenever the FSM is not IDLE
//   retry_cnt   saturating count of start retries since reset
//   state_dbg   current FSM state (IDLE=0, START=1, WAIT_ACK=2, WAIT_DONE=3)
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ACK_TO     = 16
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_scheduler_if.slave bus,
  output logic               sched_busy,
  output logic [3:0]         retry_cnt,
  output logic [1:0]         state_dbg
);

  // Timer only needs to reach ACK_TO-2 (see WAIT_ACK).
  localparam int TW = (ACK_TO > 2) ? $clog2(ACK_TO) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hi_byte_q, hi_byte_d;
  logic                  last_byte_q, last_byte_d;
  logic                  ptr_q, ptr_d;        // 1 = favour req1
  logic [TW-1:0]         timer_q, timer_d;
  logic [3:0]            retry_q, retry_d;
  logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;
  logic                  tx_data_valid_q, tx_data_valid_d;
  logic                  sched_busy_q, sched_busy_d;

  logic grant0, grant1;

  // With both valid, the pointer picks the requester not granted last.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);

  // Ready is qualified with RST so it reads 0 while reset is asserted even
  // if a requester keeps valid high.
  assign bus.req0_ready = (state_q == IDLE) & RST & grant0;
  assign bus.req1_ready = (state_q == IDLE) & RST & grant1;

  always_comb begin
    state_d     = state_q;
    hi_byte_d   = hi_byte_q;
    last_byte_d = last_byte_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    tx_p_data_d = tx_p_data_q;

    case (state_q)
      IDLE: begin
        if (grant0) begin
          tx_p_data_d = bus.req0_data;
          last_byte_d = 1'b1;
          ptr_d       = 1'b1;
          state_d     = START;
        end else if (grant1) begin
          tx_p_data_d = bus.req1_data[DATA_WIDTH-1:0];
          hi_byte_d   = bus.req1_data[2*DATA_WIDTH-1:DATA_WIDTH];
          last_byte_d = 1'b0;
          ptr_d       = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(ACK_TO - 2)) begin
          // Timer is about to reach ACK_TO-1: the pulse was lost, resend the
          // same byte. The retry start lands ACK_TO cycles after the first.
          state_d = START;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_byte_q) begin
            state_d = IDLE;
          end else begin
            tx_p_data_d = hi_byte_q;
            last_byte_d = 1'b1;
            state_d     = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    tx_data_valid_d = (state_d == START);
    sched_busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q         <= IDLE;
      hi_byte_q       <= '0;
      last_byte_q     <= 1'b0;
      ptr_q           <= 1'b0;
      timer_q         <= '0;
      retry_q         <= '0;
      tx_p_data_q     <= '0;
      tx_data_valid_q <= 1'b0;
      sched_busy_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      hi_byte_q       <= hi_byte_d;
      last_byte_q     <= last_byte_d;
      ptr_q           <= ptr_d;
      timer_q         <= timer_d;
      retry_q         <= retry_d;
      tx_p_data_q     <= tx_p_data_d;
      tx_data_valid_q <= tx_data_valid_d;
      sched_busy_q    <= sched_busy_d;
    end
  end

  assign bus.tx_p_data     = tx_p_data_q;
  assign bus.tx_data_valid = tx_data_valid_q;
  assign sched_busy        = sched_busy_q;
  assign retry_cnt         = retry_q;
  assign state_dbg         = state_q;

endmodule
